// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART link transmitter and receiver.
// Frame layout: one start bit, DATA_BITS data bits LSB first, one stop bit.
package uart_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   DFLT_DATA_BITS = 8;
    localparam int   FRAME_BITS     = DFLT_DATA_BITS + 2;
    localparam logic IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise.
// Ports: clock, reset (sync, high), enable in; bit_end out on the last cycle of a bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign bit_end = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (!enable || bit_end) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_link_tx.sv
// 8N1 serial transmitter behind a level transmit/busy handshake.
// Ports: clock, reset, data_in, transmit in; busy, tx, done out.
module uart_link_tx
    import uart_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 transmit,
    output logic                 busy,
    output logic                 tx,
    output logic                 done
);

    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
    logic                 accept;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock  (clock),
        .reset  (reset),
        .enable (state_q != IDLE),
        .bit_end(bit_end)
    );

    // armed only re-arms once transmit has been seen low, so a request
    // still held high after a frame cannot start another one.
    assign accept = (state_q == IDLE) && transmit && armed_q && !reset;
    assign busy   = !reset && ((state_q != IDLE) || accept);
    assign done   = !reset && (state_q == STOP) && bit_end;
    assign tx     = tx_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        armed_d = armed_q;
        tx_d    = IDLE_LEVEL;

        if (accept) begin
            armed_d = 1'b0;
        end else if (!transmit) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = data_in;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx changes on the same
        // edge as the state it belongs to.
        unique case (state_d)
            IDLE:    tx_d = IDLE_LEVEL;
            START:   tx_d = ~IDLE_LEVEL;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = IDLE_LEVEL;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

endmodule
